// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_pkg;

    // Device address that marks the end of the configuration table.
    localparam logic [6:0] TERM_DEV = 7'h7F;
    // R/W bit appended to the 7-bit device address; the sequencer only writes.
    localparam logic       I2C_WR   = 1'b0;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLaunch,
        StXfer,
        StDrain,
        StBackoff,
        StNext,
        StDone,
        StErr
    } seq_state_t;

    // One table entry; field order matches the 23-bit table_entry bus.
    typedef struct packed {
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] val;
    } cfg_entry_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_cfg_seq.sv
// Table-driven I2C configuration sequencer. Plays {dev, reg, val} writes through the I2C
// master controller one entry at a time, checks each ACK, retries NACKed entries after a
// back-off, aborts hung transactions with a watchdog and reports the first failing entry.
module i2c_cfg_seq
    import i2c_pkg::*;
#(
    parameter int unsigned N_ENTRIES   = 16,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BACKOFF_CYC = 1000,
    parameter int unsigned TIMEOUT_CYC = 200000,
    localparam int unsigned IW         = $clog2(N_ENTRIES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic [IW-1:0] table_idx,
    input  logic [22:0]   table_entry,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_idx,
    output logic          ctrl_feed_n,
    output logic [7:0]    ctrl_addr,
    output logic [7:0]    ctrl_tx_data,
    input  logic          ctrl_active,
    input  logic          ctrl_ack_vld,
    input  logic          ctrl_tx_ack
);

    // Watchdog and back-off share one down-counter; they never run at the same time.
    localparam int unsigned CW = $clog2(max_u(TIMEOUT_CYC, BACKOFF_CYC) + 1);
    localparam int unsigned RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] WdogLoad = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] BoffLoad = CW'(BACKOFF_CYC - 1);
    localparam logic [IW-1:0] LastIdx  = IW'(N_ENTRIES - 1);
    localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    ack_cnt_q, ack_cnt_d;
    logic          ok_q, ok_d;
    logic          idle_seen_q, idle_seen_d;
    cfg_entry_t    entry_q, entry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [IW-1:0] err_idx_q, err_idx_d;
    logic          feed_n_q, feed_n_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    tx_q, tx_d;

    cfg_entry_t    fetched;
    logic          in_attempt;

    assign fetched    = cfg_entry_t'(table_entry);
    assign in_attempt = (state_q == StLaunch) || (state_q == StXfer) || (state_q == StDrain);

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            retry_q     <= '0;
            ack_cnt_q   <= '0;
            ok_q        <= 1'b0;
            idle_seen_q <= 1'b0;
            entry_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_idx_q   <= '0;
            feed_n_q    <= 1'b1;
            addr_q      <= '0;
            tx_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            ack_cnt_q   <= ack_cnt_d;
            ok_q        <= ok_d;
            idle_seen_q <= idle_seen_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_idx_q   <= err_idx_d;
            feed_n_q    <= feed_n_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
        end
    end

    // Next-state and next-output logic; the watchdog override at the end has the last word.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        ack_cnt_d   = ack_cnt_q;
        ok_d        = ok_q;
        idle_seen_d = idle_seen_q;
        entry_d     = entry_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_idx_d   = err_idx_q;
        feed_n_d    = feed_n_q;
        addr_d      = addr_q;
        tx_d        = tx_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    idx_d   = '0;
                    retry_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end

            StFetch: begin
                entry_d = fetched;
                if (fetched.dev == TERM_DEV) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d       = WdogLoad;
                    idle_seen_d = 1'b0;
                    state_d     = StLaunch;
                end
            end

            StLaunch: begin
                cnt_d     = cnt_q - CW'(1);
                feed_n_d  = 1'b0;
                addr_d    = {entry_q.dev, I2C_WR};
                tx_d      = entry_q.reg_addr;
                ack_cnt_d = '0;
                // After a reset the controller may still be finishing an old transaction;
                // only a fresh assertion of ctrl_active belongs to this launch.
                if (!ctrl_active) begin
                    idle_seen_d = 1'b1;
                end
                if (ctrl_active && idle_seen_q) begin
                    state_d = StXfer;
                end
            end

            StXfer: begin
                cnt_d = cnt_q - CW'(1);
                if (ctrl_ack_vld) begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                    if (ctrl_tx_ack) begin
                        feed_n_d = 1'b1;
                        ok_d     = 1'b0;
                        state_d  = StDrain;
                    end else if (ack_cnt_q == 2'd1) begin
                        tx_d = entry_q.val;
                    end else if (ack_cnt_q == 2'd2) begin
                        feed_n_d = 1'b1;
                        ok_d     = 1'b1;
                        state_d  = StDrain;
                    end
                end
            end

            StDrain: begin
                cnt_d = cnt_q - CW'(1);
                if (!ctrl_active) begin
                    if (ok_q) begin
                        state_d = StNext;
                    end else if (retry_q < RetryMax) begin
                        retry_d = retry_q + RW'(1);
                        cnt_d   = BoffLoad;
                        state_d = StBackoff;
                    end else begin
                        err_idx_d = idx_q;
                        error_d   = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = StErr;
                    end
                end
            end

            StBackoff: begin
                if (cnt_q == '0) begin
                    cnt_d       = WdogLoad;
                    idle_seen_d = 1'b0;
                    state_d     = StLaunch;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            StNext: begin
                retry_d = '0;
                if (idx_q == LastIdx) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog expiry: no retry, and it beats any ACK strobe in the same cycle.
        if (in_attempt && (cnt_q == '0)) begin
            cnt_d     = '0;
            feed_n_d  = 1'b1;
            err_idx_d = idx_q;
            error_d   = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = StErr;
        end
    end

    assign table_idx    = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_idx      = err_idx_q;
    assign ctrl_feed_n  = feed_n_q;
    assign ctrl_addr    = addr_q;
    assign ctrl_tx_data = tx_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: a behavioural I2C controller model plus a table-level reference
// model that predicts every attempt's byte stream and the final status of each run.
module tb_i2c_cfg_seq;

    localparam int unsigned NE   = 16;
    localparam int unsigned MR   = 3;
    localparam int unsigned BO   = 8;
    localparam int unsigned TO   = 50;
    localparam int unsigned IW   = 4;
    localparam int          NOBS = 4096;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [IW-1:0] table_idx;
    logic [22:0]   table_entry;
    logic          busy, done, error;
    logic [IW-1:0] err_idx;
    logic          ctrl_feed_n;
    logic [7:0]    ctrl_addr, ctrl_tx_data;
    logic          ctrl_active, ctrl_ack_vld, ctrl_tx_ack;

    always #5 clk = ~clk;

    logic [22:0] tbl [NE];
    assign table_entry = tbl[table_idx];

    i2c_cfg_seq #(
        .N_ENTRIES   (NE),
        .MAX_RETRY   (MR),
        .BACKOFF_CYC (BO),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .table_idx    (table_idx),
        .table_entry  (table_entry),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_idx      (err_idx),
        .ctrl_feed_n  (ctrl_feed_n),
        .ctrl_addr    (ctrl_addr),
        .ctrl_tx_data (ctrl_tx_data),
        .ctrl_active  (ctrl_active),
        .ctrl_ack_vld (ctrl_ack_vld),
        .ctrl_tx_ack  (ctrl_tx_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- controller model ----------------
    int         ctl_mode = 0;       // 0 = responds, 1 = never goes active
    int         nack_q[$];          // per transaction: 0 = ACK all, k = NACK byte k
    logic [7:0] obs_byte [NOBS][3];
    int         obs_len  [NOBS];
    int         obs_cnt = 0;

    task automatic run_xfer();
        int t;
        int slot;
        bit abort;
        t    = obs_cnt;
        slot = (nack_q.size() != 0) ? nack_q.pop_front() : 0;
        if (t < NOBS) obs_len[t] = 0;
        obs_cnt++;
        ctrl_active = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            if (t < NOBS) begin
                obs_byte[t][b] = (b == 0) ? ctrl_addr : ctrl_tx_data;
                obs_len[t]     = b + 1;
            end
            abort = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (ctrl_feed_n) abort = 1'b1;
            end
            @(negedge clk);
            ctrl_ack_vld = 1'b1;
            ctrl_tx_ack  = (slot == b + 1);
            @(negedge clk);
            ctrl_ack_vld = 1'b0;
            ctrl_tx_ack  = 1'b0;
            @(negedge clk);
            if ((slot == b + 1) || abort || ctrl_feed_n) break;
        end
        @(negedge clk);
        ctrl_active = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ctrl_active  = 1'b0;
        ctrl_ack_vld = 1'b0;
        ctrl_tx_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (ctl_mode == 0 && rstn && !ctrl_feed_n) run_xfer();
        end
    end

    // Length of each feed_n-high stretch that ends in a launch.
    int   gap_q[$];
    int   hi_run = 0;
    logic prev_feed_n = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (ctrl_feed_n) begin
                hi_run++;
            end else begin
                if (prev_feed_n) gap_q.push_back(hi_run);
                hi_run = 0;
            end
            prev_feed_n = ctrl_feed_n;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0][7:0] b;
        int              len;
        bit              retry;
    } att_t;

    int   plan [NE][MR+1];
    att_t exp_q[$];
    bit   exp_err;
    int   exp_eidx;
    int   exp_last;

    task automatic model_run();
        att_t a;
        bit   ok;
        exp_q.delete();
        nack_q.delete();
        exp_err  = 1'b0;
        exp_eidx = 0;
        exp_last = NE - 1;
        for (int i = 0; i < NE; i++) begin
            if (tbl[i][22:16] == 7'h7F) begin
                exp_last = i;
                return;
            end
            ok = 1'b0;
            for (int k = 0; k <= MR; k++) begin
                a.b[0]  = {tbl[i][22:16], 1'b0};
                a.b[1]  = tbl[i][15:8];
                a.b[2]  = tbl[i][7:0];
                a.len   = (plan[i][k] == 0) ? 3 : plan[i][k];
                a.retry = (k > 0);
                exp_q.push_back(a);
                nack_q.push_back(plan[i][k]);
                if (plan[i][k] == 0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                exp_err  = 1'b1;
                exp_eidx = i;
                exp_last = i;
                return;
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NE; i++)
            for (int k = 0; k <= MR; k++) plan[i][k] = 0;
    endtask

    task automatic cmp_streams(input string tag, input int base, input int first);
        for (int k = first; k < exp_q.size(); k++) begin
            if (base + k < obs_cnt && base + k < NOBS) begin
                check_eq($sformatf("%s.len%0d", tag, k), obs_len[base + k], exp_q[k].len);
                for (int j = 0; j < exp_q[k].len && j < obs_len[base + k]; j++)
                    check_eq($sformatf("%s.t%0d.b%0d", tag, k, j),
                             obs_byte[base + k][j], exp_q[k].b[j]);
            end
        end
    endtask

    // Plays the current table once and compares everything against the model.
    task automatic run_and_check(input string tag, input bit poke);
        int base, cyc, max_idx, poke_at;
        model_run();
        base    = obs_cnt;
        max_idx = 0;
        poke_at = poke ? int'($urandom_range(3, 40)) : -1;
        gap_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check_eq({tag, ".busy_up"}, busy, 1'b1);
        check_eq({tag, ".done_clr"}, done, 1'b0);
        while (!done && cyc < 6000) begin
            if (cyc == poke_at && busy) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (int'(table_idx) > max_idx) max_idx = int'(table_idx);
        end
        check_eq({tag, ".finished"}, (cyc < 6000), 1'b1);
        repeat (3) @(negedge clk);
        check_eq({tag, ".done"}, done, 1'b1);
        check_eq({tag, ".busy"}, busy, 1'b0);
        check_eq({tag, ".error"}, error, exp_err);
        if (exp_err) check_eq({tag, ".err_idx"}, err_idx, exp_eidx);
        check_eq({tag, ".feed_n"}, ctrl_feed_n, 1'b1);
        check_eq({tag, ".table_idx"}, table_idx, exp_last);
        check_eq({tag, ".max_idx"}, max_idx, exp_last);
        check_eq({tag, ".n_xfer"}, obs_cnt - base, exp_q.size());
        check_eq({tag, ".n_launch"}, gap_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < gap_q.size(); k++)
            if (exp_q[k].retry)
                check_eq($sformatf("%s.backoff%0d", tag, k), (gap_q[k] >= int'(BO)), 1'b1);
        cmp_streams(tag, base, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base, cyc, term;
        rstn  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NE; i++) tbl[i] = 23'h0;
        clear_plan();
        repeat (3) @(negedge clk);
        check_eq("rst.table_idx", table_idx, 0);
        check_eq("rst.feed_n", ctrl_feed_n, 1'b1);
        check_eq("rst.addr", ctrl_addr, 0);
        check_eq("rst.tx_data", ctrl_tx_data, 0);
        check_eq("rst.busy", busy, 1'b0);
        check_eq("rst.done", done, 1'b0);
        check_eq("rst.error", error, 1'b0);
        check_eq("rst.err_idx", err_idx, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Two writes then terminator, all ACKed.
        tbl[0] = {7'h3C, 8'h10, 8'hA5};
        tbl[1] = {7'h3C, 8'h11, 8'h5A};
        tbl[2] = {7'h7F, 8'h00, 8'h00};
        run_and_check("basic", 1'b0);

        // Address NACKed twice, then accepted.
        plan[0][0] = 1;
        plan[0][1] = 1;
        run_and_check("retry", 1'b0);

        // Value byte of entry 1 NACKed on every attempt; entry 2 must not be reached.
        clear_plan();
        tbl[2] = {7'h22, 8'h33, 8'h44};
        tbl[3] = {7'h7F, 8'h00, 8'h00};
        for (int k = 0; k <= MR; k++) plan[1][k] = 3;
        run_and_check("nack_val", 1'b0);
        clear_plan();

        // Controller never goes active: watchdog fires 50 cycles after LAUNCH.
        ctl_mode = 1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!error && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                check_eq("wdog.feed_low", ctrl_feed_n, 1'b0);
                check_eq("wdog.addr", ctrl_addr, 8'h78);
            end
        end
        check_eq("wdog.cycles", cyc, 52);
        check_eq("wdog.err_idx", err_idx, 0);
        check_eq("wdog.done", done, 1'b1);
        check_eq("wdog.busy", busy, 1'b0);
        check_eq("wdog.feed_n", ctrl_feed_n, 1'b1);
        ctl_mode = 0;
        repeat (2) @(negedge clk);

        // Full table, no terminator.
        for (int i = 0; i < NE; i++)
            tbl[i] = {7'($urandom_range(0, 126)), 8'($urandom), 8'($urandom)};
        run_and_check("full", 1'b1);

        // Reset during the register byte, then restart while the old transfer is active.
        tbl[0] = {7'h51, 8'h02, 8'hC3};
        tbl[1] = {7'h19, 8'h7E, 8'h0F};
        tbl[2] = {7'h7F, 8'h00, 8'h00};
        model_run();
        nack_q.push_front(0);
        base  = obs_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(obs_cnt > base && obs_len[base] >= 2) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mrst.reached_reg", (cyc < 200), 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("mrst.feed_n", ctrl_feed_n, 1'b1);
        check_eq("mrst.busy", busy, 1'b0);
        check_eq("mrst.done", done, 1'b0);
        check_eq("mrst.table_idx", table_idx, 0);
        check_eq("mrst.addr", ctrl_addr, 0);
        check_eq("mrst.tx_data", ctrl_tx_data, 0);
        rstn  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check_eq("mrst.done_after", done, 1'b1);
        check_eq("mrst.error", error, 1'b0);
        check_eq("mrst.old_len", obs_len[base], 2);
        check_eq("mrst.n_xfer", obs_cnt - base, 3);
        cmp_streams("mrst", base + 1, 0);

        // Randomised tables and NACK patterns.
        for (int r = 0; r < 20; r++) begin
            term = ($urandom_range(0, 2) == 0) ? NE : int'($urandom_range(0, NE - 1));
            for (int i = 0; i < NE; i++) begin
                tbl[i] = {7'($urandom_range(0, 126)), 8'($urandom), 8'($urandom)};
                if (i == term) tbl[i][22:16] = 7'h7F;
                for (int k = 0; k <= MR; k++)
                    plan[i][k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                if ($urandom_range(0, 11) == 0)
                    for (int k = 0; k <= MR; k++) plan[i][k] = int'($urandom_range(1, 3));
            end
            run_and_check($sformatf("rnd%0d", r), r[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_seq.md
# i2c_cfg_seq

Table-driven configuration sequencer that sits in front of the I2C master controller and plays a list of 3-byte register writes (device address, register, value) to peripherals after power-up or on demand. It fetches each entry from an external constant table, launches and steers one controller transaction per entry, and checks every ACK. It retries NACKed entries with back-off, aborts hung transactions through a watchdog, and reports completion and the first failing entry.

## Interface
- N_ENTRIES, 16: table depth; IW = $clog2(N_ENTRIES).
- MAX_RETRY, 3: retries per entry after the first attempt.
- BACKOFF_CYC, 1000: idle clk cycles between a failed attempt and its retry.
- TIMEOUT_CYC, 200000: watchdog limit per attempt, counted from launch.
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  begin playing the table; honoured only in IDLE, DONE, or ERR.
- table_idx  out  IW  index of the entry being fetched.
- table_entry  in  23  {dev[6:0], reg[7:0], val[7:0]}; combinational read of table_idx.
- busy  out  1  high from start acceptance until DONE or ERR.
- done  out  1  level; high in DONE and ERR until the next accepted start.
- error  out  1  level; high in ERR only.
- err_idx  out  IW  index of the failing entry; valid while error is high.
- ctrl_feed_n  out  1  to controller; low = start or continue the transaction.
- ctrl_addr  out  8  {dev, 1'b0}; always a write.
- ctrl_tx_data  out  8  byte for the controller's next transmit slot.
- ctrl_active  in  1  controller in a transaction (START through STOP).
- ctrl_ack_vld  in  1  1-cycle strobe when the controller samples an ACK bit.
- ctrl_tx_ack  in  1  sampled ACK bit; 0 = ACK, 1 = NACK; valid with ctrl_ack_vld.

## Operation
- States: IDLE, FETCH, LAUNCH, XFER, DRAIN, BACKOFF, NEXT, DONE, ERR.
- IDLE/DONE/ERR + start:
  - table_idx←0, retry←0, done←0, error←0.
  - Then go to FETCH.
- FETCH (1 cycle): latch table_entry.
  - If dev==7'h7F (terminator), go to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - ctrl_feed_n←0, ctrl_addr←{dev,0}, ctrl_tx_data←reg, ack_cnt←0.
  - On ctrl_active==1, go to XFER.
- XFER: each ctrl_ack_vld increments ack_cnt (1 = addr, 2 = reg, 3 = val).
  - ACK with ack_cnt→1: no change.
  - ACK with ack_cnt→2: ctrl_tx_data←val, next cycle.
  - ACK with ack_cnt→3: ctrl_feed_n←1, ok←1, go to DRAIN.
  - NACK at any slot: ctrl_feed_n←1, ok←0, go to DRAIN.
- DRAIN: wait for ctrl_active==0.
  - ok: go to NEXT.
  - Not ok and retry<MAX_RETRY: retry++, go to BACKOFF.
  - Otherwise: err_idx←table_idx, go to ERR.
- BACKOFF: count BACKOFF_CYC cycles, then go to LAUNCH (same entry).
- NEXT:
  - retry←0.
  - If table_idx==N_ENTRIES-1, go to DONE.
  - Otherwise table_idx++, go to FETCH.
- Watchdog: counts in LAUNCH, XFER, and DRAIN; resets on leaving BACKOFF or FETCH.
  - Reaching TIMEOUT_CYC-1 means ctrl_feed_n←1, err_idx←table_idx, go to ERR.
  - No retry on timeout.
- ERR: error=1, done=1, busy=0, ctrl_feed_n=1.

## Timing
- Reset values:
  - ctrl_feed_n=1; ctrl_addr, ctrl_tx_data, table_idx, err_idx = 0.
  - busy, done, error = 0.
  - State IDLE; all counters 0.
- start→busy: 1 cycle. start→ctrl_feed_n low: 3 cycles (accept, FETCH, LAUNCH).
- start while busy: ignored, no effect.
- ctrl_ack_vld outside XFER: ignored.
- ctrl_ack_vld coincident with the timeout cycle: timeout wins.
- ctrl_feed_n rises the cycle after the 3rd ACK strobe, so the controller issues STOP after val.
- ctrl_tx_data holds reg until the 2nd ACK strobe, then val the next cycle, inside the ACK slot.
- Reset mid-transaction:
  - ctrl_feed_n=1 on the next edge.
  - The controller finishes its current byte and stops.
  - A new start during ctrl_active==1 waits in LAUNCH; feed_n stays low.
- All outputs registered. Watchdog and backoff counter width: $clog2(max(TIMEOUT_CYC, BACKOFF_CYC)+1).

## Structure
- Shared package i2c_pkg holds:
  - seq_state_t enum.
  - cfg_entry_t packed struct {dev, reg, val}.
  - Constants TERM_DEV=7'h7F and I2C_WR=1'b0.
- Single module, no sub-module. One shared down-counter serves both watchdog and backoff, since they never run concurrently.

## Test plan
- Table {0x3C,0x10,0xA5}, {0x3C,0x11,0x5A}, then terminator; controller model ACKs everything.
  - Response: 2 transactions with byte streams 0x78,0x10,0xA5 and 0x78,0x11,0x5A.
  - done=1, error=0, busy=0.
- Entry 0 NACKs the address twice, then ACKs, with BACKOFF_CYC=8.
  - Response: 3 launches.
  - ctrl_feed_n stays high ≥8 cycles between attempts.
  - Success; done=1, error=0.
- Entry 1 NACKs the val byte on every attempt.
  - Response: 4 attempts, then error=1, err_idx=1, done=1.
  - Entry 2 never fetched.
- Controller model never asserts ctrl_active, with TIMEOUT_CYC=50.
  - Response: error=1 and err_idx=0 exactly 50 cycles after LAUNCH; ctrl_feed_n=1.
- Full 16-entry table with no terminator.
  - Response: 16 transactions; table_idx stops at 15; done=1.
- rstn low during the reg byte.
  - Response: next cycle ctrl_feed_n=1 and all outputs at reset values.
  - A start re-asserted while ctrl_active=1 launches only after ctrl_active falls.
